// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into the instruction memory
// and holds the core in reset until a complete image with a good checksum lands.
module imem_loader #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic [7:0]        instruction_mem [MEM_BYTES],
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d, sum_add;
  logic [7:0]        mem_q [MEM_BYTES];
  logic              beat;
  logic              wr_en;

  assign in_ready = (state_q inside {S_LEN, S_DATA, S_CSUM}) && !load_start;
  assign beat     = in_valid && in_ready;
  assign sum_add  = sum_q + in_byte;
  assign cnt_inc  = cnt_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    wr_en   = 1'b0;
    // load_start wins over any beat; in_ready is already low so nothing is consumed
    if (load_start) begin
      state_d = S_LEN;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (beat) begin
      case (state_q)
        S_LEN: begin
          len_d   = (in_byte == 8'h00) ? (ADDR_W+1)'(MEM_BYTES) : (ADDR_W+1)'(in_byte);
          sum_d   = in_byte;
          addr_d  = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          wr_en  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_inc;
          sum_d  = sum_add;
          if (cnt_inc == len_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          sum_d   = sum_add;
          state_d = (sum_add == 8'h00) ? S_DONE : S_ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[addr_q] <= in_byte;
    end
  end

  assign instruction_mem = mem_q;
  assign cpu_reset       = (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign error           = (state_q == S_ERROR);
  assign byte_count      = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table plus hand sequences
// for the full image, random backpressure and asynchronous reset mid-load.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic [7:0] instruction_mem [256];
  logic       cpu_reset;
  logic       done;
  logic       error;
  logic [8:0] byte_count;

  int checks = 0;
  int errors = 0;

  imem_loader #(.MEM_BYTES(256), .ADDR_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_start      (load_start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_byte         (in_byte),
    .instruction_mem (instruction_mem),
    .cpu_reset       (cpu_reset),
    .done            (done),
    .error           (error),
    .byte_count      (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One record per clock: inputs driven before the edge, in_ready expected
  // before the edge, the remaining outputs expected after the edge.
  typedef struct {
    logic       ls;
    logic       vld;
    logic [7:0] b;
    logic       rdy;
    logic       dn;
    logic       er;
    logic       crst;
    logic [8:0] cnt;
    logic       mchk;
    logic [7:0] maddr;
    logic [7:0] mval;
  } vec_t;

  vec_t vecs [24];

  task automatic send_beat(input logic [7:0] b, input string name);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = 8'hEE;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  initial begin
    int bad;
    logic [7:0] csum;
    logic [7:0] img4 [4];

    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;

    //                ls  vld  byte   rdy dn er crst cnt  mchk addr val
    vecs[0]  = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[1]  = '{1'b1,1'b1,8'h04, 1'b0,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[2]  = '{1'b0,1'b1,8'h04, 1'b1,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[3]  = '{1'b0,1'b1,8'h8C, 1'b1,1'b0,1'b0,1'b1,9'd1, 1'b1,8'h00,8'h8C};
    vecs[4]  = '{1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,1'b1,9'd2, 1'b1,8'h01,8'h01};
    vecs[5]  = '{1'b0,1'b0,8'h5A, 1'b1,1'b0,1'b0,1'b1,9'd2, 1'b1,8'h02,8'h00};
    vecs[6]  = '{1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b1,9'd3, 1'b0,8'h00,8'h00};
    vecs[7]  = '{1'b0,1'b1,8'h00, 1'b1,1'b0,1'b0,1'b1,9'd4, 1'b0,8'h00,8'h00};
    vecs[8]  = '{1'b0,1'b1,8'h6F, 1'b1,1'b1,1'b0,1'b0,9'd4, 1'b1,8'h00,8'h8C};
    vecs[9]  = '{1'b0,1'b1,8'h55, 1'b0,1'b1,1'b0,1'b0,9'd4, 1'b1,8'h04,8'h00};
    vecs[10] = '{1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[11] = '{1'b0,1'b1,8'h02, 1'b1,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[12] = '{1'b0,1'b1,8'hAA, 1'b1,1'b0,1'b0,1'b1,9'd1, 1'b1,8'h00,8'hAA};
    vecs[13] = '{1'b0,1'b1,8'h55, 1'b1,1'b0,1'b0,1'b1,9'd2, 1'b1,8'h01,8'h55};
    vecs[14] = '{1'b0,1'b1,8'h01, 1'b1,1'b0,1'b1,1'b1,9'd2, 1'b0,8'h00,8'h00};
    vecs[15] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,9'd2, 1'b0,8'h00,8'h00};
    vecs[16] = '{1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[17] = '{1'b0,1'b1,8'h04, 1'b1,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[18] = '{1'b0,1'b1,8'h11, 1'b1,1'b0,1'b0,1'b1,9'd1, 1'b1,8'h00,8'h11};
    vecs[19] = '{1'b0,1'b1,8'h22, 1'b1,1'b0,1'b0,1'b1,9'd2, 1'b1,8'h01,8'h22};
    vecs[20] = '{1'b1,1'b1,8'h33, 1'b0,1'b0,1'b0,1'b1,9'd0, 1'b1,8'h02,8'h00};
    vecs[21] = '{1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,1'b1,9'd0, 1'b0,8'h00,8'h00};
    vecs[22] = '{1'b0,1'b1,8'h77, 1'b1,1'b0,1'b0,1'b1,9'd1, 1'b1,8'h00,8'h77};
    vecs[23] = '{1'b0,1'b1,8'h88, 1'b1,1'b1,1'b0,1'b0,9'd1, 1'b1,8'h01,8'h22};

    // reset-only state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_byte_count", {23'd0, byte_count}, 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (instruction_mem[i] !== 8'h00) bad++;
    check("rst_mem_nonzero_cnt", bad, 0);

    // good load, bad checksum, restart mid-load
    for (int v = 0; v < 24; v++) begin
      @(negedge clk);
      load_start = vecs[v].ls;
      in_valid   = vecs[v].vld;
      in_byte    = vecs[v].b;
      #1;
      check($sformatf("v%0d_in_ready", v), {31'd0, in_ready}, {31'd0, vecs[v].rdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].dn});
      check($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vecs[v].er});
      check($sformatf("v%0d_cpu_reset", v), {31'd0, cpu_reset}, {31'd0, vecs[v].crst});
      check($sformatf("v%0d_byte_count", v), {23'd0, byte_count}, {23'd0, vecs[v].cnt});
      if (vecs[v].mchk)
        check($sformatf("v%0d_mem", v), {24'd0, instruction_mem[vecs[v].maddr]}, {24'd0, vecs[v].mval});
    end
    load_start = 1'b0; in_valid = 1'b0;
    check("restart_mem2", {24'd0, instruction_mem[2]}, 32'h00);
    check("restart_mem3", {24'd0, instruction_mem[3]}, 32'h00);

    // full 256-byte image, L = 0
    pulse_start();
    csum = 8'h00;
    send_beat(8'h00, "full_len");
    for (int i = 0; i < 256; i++) begin
      send_beat(8'(i), "full_data");
      csum = csum + 8'(i);
    end
    check("full_not_done_early", {31'd0, done}, 32'd0);
    send_beat(8'h00 - csum, "full_csum");
    bad = 0;
    for (int i = 0; i < 256; i++) if (instruction_mem[i] !== 8'(i)) bad++;
    check("full_mem_bad_cnt", bad, 0);
    check("full_byte_count", {23'd0, byte_count}, 32'd256);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    // 4-byte load with random gaps; mem[2..3] now hold 02 03 and must become 00
    img4[0] = 8'h8C; img4[1] = 8'h01; img4[2] = 8'h00; img4[3] = 8'h00;
    pulse_start();
    send_beat(8'h04, "bp_len");
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'(($urandom & 32'hFF));
      end
      send_beat(img4[i], "bp_data");
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("bp_count_before_csum", {23'd0, byte_count}, 32'd4);
    send_beat(8'h6F, "bp_csum");
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_mem%0d", i), {24'd0, instruction_mem[i]}, {24'd0, img4[i]});
    check("bp_mem4_untouched", {24'd0, instruction_mem[4]}, 32'h04);
    check("bp_done", {31'd0, done}, 32'd1);
    check("bp_byte_count", {23'd0, byte_count}, 32'd4);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("bp_ready_after_done", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // asynchronous reset mid-load zeroes the partial image
    pulse_start();
    send_beat(8'h03, "ar_len");
    send_beat(8'hC3, "ar_data");
    check("ar_mem0_written", {24'd0, instruction_mem[0]}, 32'hC3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_mem0_zeroed", {24'd0, instruction_mem[0]}, 32'h00);
    check("ar_mem5_zeroed", {24'd0, instruction_mem[5]}, 32'h00);
    check("ar_byte_count", {23'd0, byte_count}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd0);
    check("ar_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_idle_ready", {31'd0, in_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the processor's 256-byte instruction memory from a byte stream and holds the pipeline in reset until a checksummed image has landed. It is the writer side of the instruction-memory byte array that the fetch stage reads. It sits beside the core top: its `instruction_mem` output drives the core's `instruction_mem` input, and its `cpu_reset` output drives the core's `reset`.

## Interface
- `MEM_BYTES`, 256: instruction memory depth in bytes. The core requires 256.
- `ADDR_W`, 8: byte address width, log2(MEM_BYTES).

- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_start` in 1: pulse that begins a new load. Accepted in any state.
- `in_valid` in 1: `in_byte` holds a valid byte.
- `in_ready` out 1: the loader can accept a byte this cycle.
- `in_byte` in 8: stream byte.
- `instruction_mem` out 8 x MEM_BYTES (unpacked `[7:0] [MEM_BYTES-1:0]`): memory image, registered.
- `cpu_reset` out 1: holds the core in reset.
- `done` out 1: the last load completed with a good checksum.
- `error` out 1: the last load failed its checksum.
- `byte_count` out ADDR_W+1: number of payload bytes written in the current load.

## Operation
- A beat transfers when `in_valid && in_ready` are both high at the clock edge.
- `in_ready = (state ∈ {LEN, DATA, CSUM}) && !load_start`. It is combinational and never depends on `in_valid`.
- Stream format: one length byte L, then N payload bytes, then one checksum byte.
  - N = L for L = 1..255. L = 0 means N = 256.
- Checksum rule: (L + sum of payload bytes + checksum byte) mod 256 == 0. The running sum is 8 bits and wraps.
- States:
  - IDLE: entered after reset.
  - LEN: on a beat, latch N, seed the sum with L, clear the address counter, go to DATA.
  - DATA: on a beat, write `in_byte` to `instruction_mem[addr]`, increment `addr` and `byte_count`, add the byte to the sum. After the N-th beat, go to CSUM.
  - CSUM: on a beat, add the byte. If the sum is 0, go to DONE. Otherwise go to ERROR.
  - DONE: holds until `load_start`.
  - ERROR: holds until `load_start`.
- `load_start` in any state (IDLE, LEN, DATA, CSUM, DONE, ERROR):
  - next state is LEN;
  - `done`, `error`, `byte_count` and the sum are cleared;
  - `cpu_reset` goes to 1;
  - no beat is consumed that cycle.
- Memory is not cleared by `load_start`. Bytes at addresses ≥ N keep their prior contents.
- Byte order is stream order. The first payload byte goes to address 0. The core's fetch defines how bytes assemble into words.
- `cpu_reset` is 1 in IDLE, LEN, DATA, CSUM and ERROR, and 0 only in DONE.

## Timing
- Reset values (asynchronous):
  - state = IDLE;
  - every `instruction_mem` byte = 8'h00;
  - `cpu_reset` = 1;
  - `done` = 0, `error` = 0, `byte_count` = 0;
  - `in_ready` = 0.
- A payload byte accepted at edge k is visible on `instruction_mem` and `byte_count` after edge k.
- On the checksum beat at edge k, `done` (or `error`) rises and `cpu_reset` falls (only on success) after edge k. The core therefore leaves reset on the first edge after k.
- Minimum load time is N+2 beats, one beat per cycle with no bubbles. Gaps in `in_valid` only stretch the load.
- Address wrap: for N = 256 the address counter reaches 255 and then the loader leaves DATA. `byte_count` reads 256. No address beyond 255 is written.
- `load_start` together with `in_valid` in DATA: the byte is not written and `byte_count` does not advance.
- `reset` asserted mid-load: the asynchronous return to reset values overrides everything, including a partially written image, which is zeroed.

## Test plan
- Reset only: after `reset` deasserts, `cpu_reset` = 1, `in_ready` = 0, `done` = `error` = 0, memory all 00.
- Good 4-byte load, sent after `load_start`: stream 04, 8C, 01, 00, 00, checksum 6F.
  - Required: mem[0..3] = 8C 01 00 00, `byte_count` = 4, `done` = 1, `cpu_reset` falls one cycle after the checksum beat, `in_ready` = 0 afterward.
- Full image: L = 00, then 256 bytes with value i at index i, correct checksum.
  - Required: mem[i] = i for all i, `byte_count` = 256, `done` = 1.
- Bad checksum: 02, AA, 55, checksum 01.
  - Required: `error` = 1, `cpu_reset` stays 1, mem[0..1] = AA 55.
- Restart mid-load: send 04, 11, 22; pulse `load_start` while `in_valid` = 1 with byte 33; then send 01, 77, 88.
  - Required: 33 is not written, `done` = 1, mem[0] = 77, mem[1] = 22 (stale), `byte_count` = 1.
- Backpressure and gaps: toggle `in_valid` randomly over the 4-byte load.
  - Required: same final image and `done` as the good 4-byte load; no duplicate or missed writes.
